perceptron_predictor: RTL and testbench
=======================================

PERCEPTRON_PREDICTOR -- requirements
Module: perceptron_predictor

Interface
REQ-001 SHALL have parameter HIST_LEN, default 8: global history length (bits), also weights per entry excluding bias; legal 2..32.
REQ-002 SHALL have parameter ENTRIES, default 64: perceptron rows, power of two; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter W_WIDTH, default 8: signed two's-complement weight width.
REQ-004 SHALL have parameter PC_WIDTH, default 32: program-counter width.
REQ-005 SHALL have parameter THETA, default 29: training threshold; SUM_W = W_WIDTH + clog2(HIST_LEN+1) + 1.
REQ-006 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports pred_req in 1 (fetch-stage branch lookup) and pred_pc in PC_WIDTH (its PC).
REQ-009 SHALL have outputs pred_taken 1, pred_sum SUM_W signed, pred_idx IDX_W, pred_ghr HIST_LEN; combinational from pred_pc and current GHR, carried down the pipeline by the core.
REQ-010 SHALL have inputs upd_valid 1, upd_idx IDX_W, upd_ghr HIST_LEN, upd_sum SUM_W, upd_taken 1 (resolved outcome), upd_mispredict 1; output upd_ready 1.

Function
REQ-011 Index SHALL be pred_idx = pred_pc[IDX_W+1:2] XOR GHR low IDX_W bits (GHR zero-extended when HIST_LEN < IDX_W); pred_ghr = current GHR.
REQ-012 Row SHALL hold bias w0 and w1..wHIST_LEN; pred_sum = w0 + sum over i of (GHR[i-1] ? +wi : -wi), sign-extended to SUM_W, no overflow.
REQ-013 pred_taken SHALL be 1 when pred_sum >= 0, else 0.
REQ-014 On pred_req, GHR SHALL shift: GHR <= {GHR[HIST_LEN-2:0], pred_taken} (bit 0 newest) at the next edge.
REQ-015 Update accepted when upd_valid && upd_ready; fields latched on acceptance; upd_valid while upd_ready=0 SHALL be ignored (producer holds).
REQ-016 On accepted update with upd_mispredict=1, GHR SHALL load {upd_ghr[HIST_LEN-2:0], upd_taken}; this restore SHALL override a same-cycle pred_req shift.
REQ-017 Training needed when upd_mispredict=1 or |upd_sum| <= THETA; otherwise FSM stays IDLE, upd_ready stays 1.
REQ-018 FSM states IDLE, TRAIN; IDLE->TRAIN on accepted update needing training; TRAIN lasts exactly HIST_LEN+1 cycles, counter k=0..HIST_LEN, then ->IDLE.
REQ-019 In TRAIN cycle k, weight wk of row upd_idx SHALL update: w0 += (taken ? +1 : -1); wk += (ghr[k-1]==taken ? +1 : -1).
REQ-020 Weight arithmetic SHALL saturate at +(2^(W_WIDTH-1)-1) and -2^(W_WIDTH-1); no wrap.
REQ-021 upd_ready SHALL be 0 throughout TRAIN and return to 1 on the cycle after the last weight write.
REQ-022 Predictions SHALL continue during TRAIN; a lookup of the row being trained sees old weights for not-yet-written k, new ones for written k.

Reset
REQ-023 On rst, all weights SHALL clear to 0, GHR to 0, FSM to IDLE, k to 0, upd_ready to 1, asynchronously.
REQ-024 Reset asserted mid-TRAIN SHALL abort training with no partial weights retained.
REQ-025 Out of reset with pred_pc any value, outputs SHALL be pred_sum=0, pred_taken=1.

Verification (defaults)
REQ-026 Reset, pred_req=1 pred_pc=0x100 one cycle -> pred_idx=0x00, pred_sum=0, pred_taken=1; GHR=0x01 after edge.
REQ-027 Update idx=5, ghr=0x00, taken=0, mispredict=1 -> upd_ready low 9 cycles; then lookup row 5 with GHR=0 gives pred_sum=-9, pred_taken=0; GHR=0x00.
REQ-028 Same cycle pred_req=1 and mispredict update upd_ghr=0xA5 upd_taken=1 -> GHR=0x4B, speculative shift dropped.
REQ-029 130 forced-mispredict updates idx=3, ghr=0xFF, taken=1 -> all row-3 weights saturate at 127; lookup with GHR=0xFF gives pred_sum=1143.
REQ-030 Update with mispredict=0, upd_sum=40 -> no TRAIN, upd_ready stays 1, weights unchanged; upd_sum=29 -> trains.
REQ-031 rst asserted in TRAIN cycle 4 -> upd_ready=1 immediately; every row reads pred_sum=0.

Source files
------------

// File: rtl/perceptron_predictor.sv
// Perceptron branch predictor: per-row signed weight vectors indexed by
// PC xor global history, a combinational dot-product lookup, and a
// sequential trainer that rewrites one weight per cycle of a trained row.
module perceptron_predictor #(
    parameter  int HIST_LEN = 8,
    parameter  int ENTRIES  = 64,
    parameter  int W_WIDTH  = 8,
    parameter  int PC_WIDTH = 32,
    parameter  int THETA    = 29,
    localparam int IDX_W    = $clog2(ENTRIES),
    localparam int SUM_W    = W_WIDTH + $clog2(HIST_LEN + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pred_req,
    input  logic [PC_WIDTH-1:0]     pred_pc,
    output logic                    pred_taken,
    output logic signed [SUM_W-1:0] pred_sum,
    output logic [IDX_W-1:0]        pred_idx,
    output logic [HIST_LEN-1:0]     pred_ghr,
    input  logic                    upd_valid,
    input  logic [IDX_W-1:0]        upd_idx,
    input  logic [HIST_LEN-1:0]     upd_ghr,
    input  logic signed [SUM_W-1:0] upd_sum,
    input  logic                    upd_taken,
    input  logic                    upd_mispredict,
    output logic                    upd_ready
);

    localparam int K_W  = $clog2(HIST_LEN + 1);
    localparam int EXT  = SUM_W - W_WIDTH;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] TRAIN = 1'b1;

    localparam logic signed [W_WIDTH-1:0] W_MAX   = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH-1:0] W_MIN   = {1'b1, {(W_WIDTH-1){1'b0}}};
    localparam logic signed [W_WIDTH-1:0] W_ONE   = W_WIDTH'(1);
    localparam logic signed [SUM_W:0]     THETA_P = (SUM_W + 1)'(THETA);
    localparam logic [K_W-1:0]            K_LAST  = K_W'(HIST_LEN);

    logic [0:0]                 state_q, state_d;
    logic [K_W-1:0]             k_q, k_d;
    logic [HIST_LEN-1:0]        ghr_q, ghr_d;
    logic [IDX_W-1:0]           updIdx_q;
    logic [HIST_LEN-1:0]        updGhr_q;
    logic                       updTaken_q;
    logic signed [W_WIDTH-1:0]  weights_q [ENTRIES][HIST_LEN+1];

    logic [IDX_W-1:0]           ghrLow;
    logic [IDX_W-1:0]           predIdx;
    logic signed [SUM_W-1:0]    sum;
    logic signed [SUM_W-1:0]    wExt;
    logic                       updAccept;
    logic                       needTrain;
    logic signed [SUM_W:0]      updSumExt;
    logic signed [W_WIDTH-1:0]  curW;
    logic signed [W_WIDTH-1:0]  newW;
    logic                       agree;
    logic                       unusedPcBits;

    // Only PC bits [IDX_W+1:2] feed the index; the rest are deliberately ignored.
    assign unusedPcBits = ^{pred_pc[PC_WIDTH-1:IDX_W+2], pred_pc[1:0]};

    // Low history bits used for indexing, zero-extended when the history is short.
    if (HIST_LEN >= IDX_W) begin : gLongHist
        assign ghrLow = ghr_q[IDX_W-1:0];
    end else begin : gShortHist
        assign ghrLow = {{(IDX_W - HIST_LEN){1'b0}}, ghr_q};
    end

    assign predIdx    = pred_pc[IDX_W+1:2] ^ ghrLow;
    assign pred_idx   = predIdx;
    assign pred_ghr   = ghr_q;
    assign pred_sum   = sum;
    assign pred_taken = ~sum[SUM_W-1];

    assign upd_ready  = (state_q == IDLE);
    assign updAccept  = upd_valid && (state_q == IDLE);
    assign updSumExt  = {upd_sum[SUM_W-1], upd_sum};
    assign needTrain  = upd_mispredict ||
                        ((updSumExt <= THETA_P) && (updSumExt >= -THETA_P));

    // Dot product of the selected row with the history encoded as +1/-1.
    always_comb begin
        sum  = {{EXT{weights_q[predIdx][0][W_WIDTH-1]}}, weights_q[predIdx][0]};
        wExt = '0;
        for (int i = 1; i <= HIST_LEN; i++) begin
            wExt = {{EXT{weights_q[predIdx][i][W_WIDTH-1]}}, weights_q[predIdx][i]};
            if (ghr_q[i-1]) begin
                sum = sum + wExt;
            end else begin
                sum = sum - wExt;
            end
        end
    end

    // Next history: a mispredict restore wins over a speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (updAccept && upd_mispredict) begin
            ghr_d = {upd_ghr[HIST_LEN-2:0], upd_taken};
        end else if (pred_req) begin
            ghr_d = {ghr_q[HIST_LEN-2:0], pred_taken};
        end
    end

    // Trainer sequencing: one weight per cycle, bias first, then w1..wHIST_LEN.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (updAccept && needTrain) begin
                    state_d = TRAIN;
                    k_d     = '0;
                end
            end
            TRAIN: begin
                if (k_q == K_LAST) begin
                    state_d = IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Saturating +1/-1 step for the weight addressed by k; the bias behaves as
    // if its history input were always 1, so it simply follows the outcome.
    always_comb begin
        curW  = weights_q[updIdx_q][k_q];
        agree = updTaken_q;
        for (int i = 1; i <= HIST_LEN; i++) begin
            if (k_q == K_W'(i)) begin
                agree = (updGhr_q[i-1] == updTaken_q);
            end
        end
        if (agree) begin
            newW = (curW == W_MAX) ? curW : curW + W_ONE;
        end else begin
            newW = (curW == W_MIN) ? curW : curW - W_ONE;
        end
    end

    // Control state, history and the fields of the update being trained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            ghr_q      <= '0;
            updIdx_q   <= '0;
            updGhr_q   <= '0;
            updTaken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ghr_q   <= ghr_d;
            if (updAccept) begin
                updIdx_q   <= upd_idx;
                updGhr_q   <= upd_ghr;
                updTaken_q <= upd_taken;
            end
        end
    end

    // Weight table: cleared on reset, one element rewritten per training cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ENTRIES; r++) begin
                for (int c = 0; c <= HIST_LEN; c++) begin
                    weights_q[r][c] <= '0;
                end
            end
        end else if (state_q == TRAIN) begin
            weights_q[updIdx_q][k_q] <= newW;
        end
    end

endmodule

// File: tb/tb_perceptron_predictor.sv
// Directed self-checking bench for perceptron_predictor at default parameters.
module tb_perceptron_predictor;

    localparam int HIST_LEN = 8;
    localparam int IDX_W    = 6;
    localparam int SUM_W    = 13;

    logic                    clk;
    logic                    rst;
    logic                    pred_req;
    logic [31:0]             pred_pc;
    logic                    pred_taken;
    logic signed [SUM_W-1:0] pred_sum;
    logic [IDX_W-1:0]        pred_idx;
    logic [HIST_LEN-1:0]     pred_ghr;
    logic                    upd_valid;
    logic [IDX_W-1:0]        upd_idx;
    logic [HIST_LEN-1:0]     upd_ghr;
    logic signed [SUM_W-1:0] upd_sum;
    logic                    upd_taken;
    logic                    upd_mispredict;
    logic                    upd_ready;

    int checkCount = 0;
    int passCount  = 0;
    int lowCount;

    perceptron_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pred_req       (pred_req),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_sum       (pred_sum),
        .pred_idx       (pred_idx),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_ghr        (upd_ghr),
        .upd_sum        (upd_sum),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .upd_ready      (upd_ready)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic valid, input logic [IDX_W-1:0] idx,
                                 input logic [HIST_LEN-1:0] ghr, input int sumVal,
                                 input logic taken, input logic mispredict);
        upd_valid      = valid;
        upd_idx        = idx;
        upd_ghr        = ghr;
        upd_sum        = SUM_W'(sumVal);
        upd_taken      = taken;
        upd_mispredict = mispredict;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (upd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(upd_ready), 1);
    endtask

    // Directed sequence.
    initial begin
        rst      = 1'b1;
        pred_req = 1'b0;
        pred_pc  = 32'h1234_5678;
        applyStimulus(1'b0, '0, '0, 0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Out of reset: empty table predicts taken with zero sum.
        checkOutput("reset_ready", 32'(upd_ready), 1);
        checkOutput("reset_sum", 32'(pred_sum), 0);
        checkOutput("reset_taken", 32'(pred_taken), 1);
        checkOutput("reset_ghr", 32'(pred_ghr), 0);
        checkOutput("reset_idx", 32'(pred_idx), 32'h1E);

        // Single lookup shifts a taken prediction into the history.
        pred_pc  = 32'h100;
        pred_req = 1'b1;
        #1;
        checkOutput("lookup_idx", 32'(pred_idx), 0);
        checkOutput("lookup_sum", 32'(pred_sum), 0);
        checkOutput("lookup_taken", 32'(pred_taken), 1);
        tick();
        pred_req = 1'b0;
        checkOutput("lookup_ghr", 32'(pred_ghr), 32'h01);

        // Mispredict training of row 5 with all-zero history, not taken.
        applyStimulus(1'b1, 6'd5, 8'h00, 0, 1'b0, 1'b1);
        #1;
        checkOutput("upd_ready_before", 32'(upd_ready), 1);
        tick();
        applyStimulus(1'b0, '0, '0, 0, 1'b0, 1'b0);
        pred_pc = 32'h14;
        #1;
        checkOutput("restore_ghr", 32'(pred_ghr), 0);
        lowCount = 0;
        while (upd_ready === 1'b0 && lowCount < 20) begin
            if (lowCount == 0) checkOutput("train_k0_old", 32'(pred_sum), 0);
            if (lowCount == 1) checkOutput("train_bias_new", 32'(pred_sum), -1);
            if (lowCount == 2) checkOutput("train_w1_new", 32'(pred_sum), -2);
            lowCount++;
            tick();
        end
        checkOutput("train_low_cycles", lowCount, 9);
        checkOutput("row5_idx", 32'(pred_idx), 5);
        checkOutput("row5_sum", 32'(pred_sum), -9);
        checkOutput("row5_taken", 32'(pred_taken), 0);

        // Confident correct prediction: no training.
        applyStimulus(1'b1, 6'd5, 8'h00, 40, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 0, 1'b0, 1'b0);
        checkOutput("confident_ready", 32'(upd_ready), 1);
        tick();
        checkOutput("confident_ready2", 32'(upd_ready), 1);
        checkOutput("confident_sum", 32'(pred_sum), -9);
        checkOutput("confident_ghr", 32'(pred_ghr), 0);

        // Sum at the threshold still trains (taken, zero history: all back to 0).
        applyStimulus(1'b1, 6'd5, 8'h00, 29, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 0, 1'b0, 1'b0);
        checkOutput("theta_ready_low", 32'(upd_ready), 0);
        waitIdle("theta_idle");
        checkOutput("theta_sum", 32'(pred_sum), 0);
        checkOutput("theta_taken", 32'(pred_taken), 1);

        // Restore overrides a same-cycle speculative shift.
        pred_req = 1'b1;
        applyStimulus(1'b1, 6'd7, 8'hA5, 0, 1'b1, 1'b1);
        tick();
        pred_req = 1'b0;
        applyStimulus(1'b0, '0, '0, 0, 1'b0, 1'b0);
        checkOutput("restore_override_ghr", 32'(pred_ghr), 32'h4B);
        waitIdle("row7_idle");
        pred_pc = 32'h30;
        #1;
        checkOutput("row7_idx", 32'(pred_idx), 7);
        checkOutput("row7_sum", 32'(pred_sum), -3);
        checkOutput("row7_taken", 32'(pred_taken), 0);

        // Repeated training of row 3 saturates every weight at +127.
        for (int n = 0; n < 130; n++) begin
            applyStimulus(1'b1, 6'd3, 8'hFF, 0, 1'b1, 1'b1);
            tick();
            applyStimulus(1'b0, '0, '0, 0, 1'b0, 1'b0);
            waitIdle("sat_idle");
        end
        pred_pc = 32'hF0;
        #1;
        checkOutput("sat_ghr", 32'(pred_ghr), 32'hFF);
        checkOutput("sat_idx", 32'(pred_idx), 3);
        checkOutput("sat_sum", 32'(pred_sum), 1143);
        checkOutput("sat_taken", 32'(pred_taken), 1);

        // Reset during training cycle k=4 aborts and clears everything.
        applyStimulus(1'b1, 6'd5, 8'h00, 0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("midtrain_busy", 32'(upd_ready), 0);
        rst = 1'b1;
        #1;
        checkOutput("midtrain_reset_ready", 32'(upd_ready), 1);
        checkOutput("midtrain_reset_ghr", 32'(pred_ghr), 0);
        #1;
        rst = 1'b0;
        for (int r = 0; r < 64; r++) begin
            pred_pc = 32'(r * 4);
            #1;
            checkOutput("cleared_row_sum", 32'(pred_sum), 0);
        end
        checkOutput("cleared_taken", 32'(pred_taken), 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
